// File: rtl/data_sram_responder.sv
// Data-memory responder: word-organised RAM with byte-lane stores and an
// in-order response queue with programmable latency and retire stall.
module data_sram_responder #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 1,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_data_req,
   input  logic        cpu_data_wr,
   input  logic [1:0]  cpu_data_size,
   input  logic [31:0] cpu_data_addr,
   input  logic [31:0] cpu_data_wdata,
   output logic        cpu_data_addr_ok,
   output logic        cpu_data_data_ok,
   output logic [31:0] cpu_data_rdata,
   input  logic        resp_stall
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [3:0]       LAT_M1  = 4'(LATENCY - 1);

   logic [31:0]       mem [2**ADDR_W];

   logic              q_valid   [DEPTH];
   logic              q_is_load [DEPTH];
   logic [31:0]       q_rdata   [DEPTH];
   logic [3:0]        q_cnt     [DEPTH];

   logic [PTR_W-1:0]  rptr;
   logic [PTR_W-1:0]  wptr;
   logic [CNT_W-1:0]  count;

   logic [ADDR_W-1:0] word_addr;
   logic [3:0]        byte_en;
   logic              push;
   logic              pop;
   logic              unused_addr_bits;

   assign word_addr        = cpu_data_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^cpu_data_addr[31:ADDR_W+2];

   // Lane selection ignores misalignment: low address bits beyond the access size are dropped.
   always_comb begin
      byte_en = 4'b1111;
      case (cpu_data_size)
         2'd0:    byte_en = 4'b0001 << cpu_data_addr[1:0];
         2'd1:    byte_en = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   assign cpu_data_addr_ok = (count < DEPTH_C);
   assign push             = cpu_data_req && cpu_data_addr_ok;
   assign cpu_data_data_ok = q_valid[rptr] && (q_cnt[rptr] == 4'd0) && !resp_stall;
   assign pop              = cpu_data_data_ok;
   assign cpu_data_rdata   = (cpu_data_data_ok && q_is_load[rptr]) ? q_rdata[rptr] : '0;

   // Load data is captured at accept time, so it reflects every earlier accepted store.
   always_ff @(posedge clk) begin
      if (push) begin
         q_is_load[wptr] <= !cpu_data_wr;
         q_rdata[wptr]   <= cpu_data_wr ? '0 : mem[word_addr];
         if (cpu_data_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (byte_en[i]) begin
                  mem[word_addr][8*i +: 8] <= cpu_data_wdata[8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_valid[i] <= 1'b0;
            q_cnt[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_cnt[i] != 4'd0)) begin
               q_cnt[i] <= q_cnt[i] - 4'd1;
            end
         end
         if (pop) begin
            q_valid[rptr] <= 1'b0;
            rptr          <= rptr + PTR_W'(1);
         end
         if (push) begin
            q_valid[wptr] <= 1'b1;
            q_cnt[wptr]   <= LAT_M1;
            wptr          <= wptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances (LATENCY 1, 2, 3)
// share stimulus; each scenario checks the instance it targets.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;

   logic        addr_ok [3];
   logic        data_ok [3];
   logic [31:0] rdata   [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(12), .LATENCY(1), .DEPTH(4)) u_lat1 (
      .clk(clk), .reset(reset), .cpu_data_req(req), .cpu_data_wr(wr),
      .cpu_data_size(size), .cpu_data_addr(addr), .cpu_data_wdata(wdata),
      .cpu_data_addr_ok(addr_ok[0]), .cpu_data_data_ok(data_ok[0]),
      .cpu_data_rdata(rdata[0]), .resp_stall(stall));

   data_sram_responder #(.ADDR_W(12), .LATENCY(2), .DEPTH(4)) u_lat2 (
      .clk(clk), .reset(reset), .cpu_data_req(req), .cpu_data_wr(wr),
      .cpu_data_size(size), .cpu_data_addr(addr), .cpu_data_wdata(wdata),
      .cpu_data_addr_ok(addr_ok[1]), .cpu_data_data_ok(data_ok[1]),
      .cpu_data_rdata(rdata[1]), .resp_stall(stall));

   data_sram_responder #(.ADDR_W(12), .LATENCY(3), .DEPTH(4)) u_lat3 (
      .clk(clk), .reset(reset), .cpu_data_req(req), .cpu_data_wr(wr),
      .cpu_data_size(size), .cpu_data_addr(addr), .cpu_data_wdata(wdata),
      .cpu_data_addr_ok(addr_ok[2]), .cpu_data_data_ok(data_ok[2]),
      .cpu_data_rdata(rdata[2]), .resp_stall(stall));

   typedef struct {
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_data_ok;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req   = 1'b0;
      wr    = 1'b0;
      size  = 2'd2;
      addr  = '0;
      wdata = '0;
      stall = 1'b0;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic store_word(input int idx, input logic [31:0] a, input logic [31:0] d);
      bit done = 0;
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = a; wdata = d;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (addr_ok[idx]) done = 1;
         next_cycle();
      end
      req = 1'b0;
      check("store accept", 32'(done), 32'd1);
   endtask

   task automatic load_check(input int idx, input logic [31:0] a, input logic [31:0] exp,
                             input string name);
      bit acc = 0;
      bit got = 0;
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = a; wdata = '0;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         if (addr_ok[idx]) acc = 1;
         next_cycle();
      end
      req = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (data_ok[idx]) begin
            got = 1;
            check(name, rdata[idx], exp);
         end
         next_cycle();
      end
      check({name, " response seen"}, 32'(got), 32'd1);
   endtask

   initial begin
      logic [31:0] vals [10];
      logic [31:0] exp_q [$];
      int issued, accepts, responses, cyc;

      vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0201, 32'h0000_AA00, 1'b1, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0202, 32'h5566_0000, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         1'b1, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 32'h5566_AA00};
      vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0300, 32'h1122_3344, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         1'b1, 32'h0};
      vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0303, 32'hEE00_0000, 1'b1, 32'h1122_3344};
      vecs[10] = '{1'b1, 1'b1, 2'd1, 32'h0000_0301, 32'h0000_BEEF, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         1'b1, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 32'hEE22_BEEF};
      vecs[13] = '{1'b1, 1'b0, 2'd2, 32'h0000_4300, 32'h0,         1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 32'hEE22_BEEF};
      vecs[15] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b0, 32'h0};

      reset = 1'b0;
      idle_inputs();
      next_cycle();
      pulse_reset();

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset addr_ok[%0d]", i), 32'(addr_ok[i]), 32'd1);
         check($sformatf("reset data_ok[%0d]", i), 32'(data_ok[i]), 32'd0);
         check($sformatf("reset rdata[%0d]", i), rdata[i], 32'h0);
      end
      next_cycle();

      // Table: LATENCY=1 store/load, byte/half lanes, size 3, ignored high address bits.
      for (int v = 0; v < 16; v++) begin
         req = vecs[v].req; wr = vecs[v].wr; size = vecs[v].size;
         addr = vecs[v].addr; wdata = vecs[v].wdata; stall = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d addr_ok", v), 32'(addr_ok[0]), 32'd1);
         check($sformatf("vec%0d data_ok", v), 32'(data_ok[0]), 32'(vecs[v].exp_data_ok));
         check($sformatf("vec%0d rdata", v), rdata[0], vecs[v].exp_rdata);
         next_cycle();
      end
      idle_inputs();

      // Full and back-pressure on the LATENCY=3 instance.
      pulse_reset();
      for (int i = 0; i < 5; i++) store_word(2, 32'h400 + 32'(4*i), 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 8; i++) next_cycle();
      req = 1'b1; wr = 1'b0; size = 2'd2; stall = 1'b1;
      for (int c = 0; c < 13; c++) begin
         addr  = (c < 4) ? 32'h400 + 32'(4*c) : 32'h410;
         req   = (c <= 8);
         stall = (c < 7);
         @(negedge clk);
         if (c < 4) begin
            check($sformatf("full c%0d addr_ok", c), 32'(addr_ok[2]), 32'd1);
            check($sformatf("full c%0d data_ok", c), 32'(data_ok[2]), 32'd0);
         end else if (c < 7) begin
            check($sformatf("full c%0d addr_ok", c), 32'(addr_ok[2]), 32'd0);
            check($sformatf("full c%0d data_ok", c), 32'(data_ok[2]), 32'd0);
         end else if (c < 12) begin
            if (c == 7) check("full c7 addr_ok", 32'(addr_ok[2]), 32'd0);
            if (c == 8) check("full c8 addr_ok", 32'(addr_ok[2]), 32'd1);
            check($sformatf("full c%0d data_ok", c), 32'(data_ok[2]), 32'd1);
            check($sformatf("full c%0d rdata", c), rdata[2], 32'hA000_0000 + 32'(c - 7));
         end else begin
            check("full c12 data_ok", 32'(data_ok[2]), 32'd0);
         end
         next_cycle();
      end
      idle_inputs();

      // Stall release on the LATENCY=2 instance.
      pulse_reset();
      for (int c = 0; c < 9; c++) begin
         req = (c == 0); wr = 1'b0; size = 2'd2; addr = 32'h400;
         stall = (c <= 5);
         @(negedge clk);
         if (c == 0) check("stall accept", 32'(addr_ok[1]), 32'd1);
         check($sformatf("stall c%0d data_ok", c), 32'(data_ok[1]), 32'(c == 6));
         if (c == 6) check("stall rdata", rdata[1], 32'hA000_0000);
         next_cycle();
      end
      idle_inputs();

      // Reset with four entries in flight on the LATENCY=3 instance.
      pulse_reset();
      for (int c = 0; c < 4; c++) begin
         req = 1'b1; stall = 1'b1; size = 2'd2;
         wr = (c == 0);
         addr = (c == 0) ? 32'h40C : 32'h400 + 32'(4*(c - 1));
         wdata = (c == 0) ? 32'hCAFE_F00D : 32'h0;
         @(negedge clk);
         check($sformatf("rstmid accept%0d", c), 32'(addr_ok[2]), 32'd1);
         next_cycle();
      end
      req = 1'b0; reset = 1'b1; stall = 1'b1;
      @(negedge clk);
      check("rstmid stalled data_ok", 32'(data_ok[2]), 32'd0);
      next_cycle();
      reset = 1'b0; stall = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) check("rstmid addr_ok", 32'(addr_ok[2]), 32'd1);
         check($sformatf("rstmid quiet%0d data_ok", c), 32'(data_ok[2]), 32'd0);
         next_cycle();
      end
      load_check(2, 32'h40C, 32'hCAFE_F00D, "rstmid store kept");

      // Pointer wrap: alternating store/load pairs with random stall.
      pulse_reset();
      for (int i = 0; i < 10; i++) vals[i] = $urandom;
      issued = 0; accepts = 0; responses = 0; cyc = 0;
      while ((issued < 20 || exp_q.size() > 0) && cyc < 400) begin
         req   = (issued < 20);
         wr    = (issued % 2 == 0);
         size  = 2'd2;
         addr  = 32'h800 + 32'(4 * (issued / 2));
         wdata = (issued < 20) ? vals[issued / 2] : 32'h0;
         stall = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         if (data_ok[2]) begin
            responses++;
            if (exp_q.size() == 0) check("wrap spurious data_ok", 32'd1, 32'd0);
            else check($sformatf("wrap resp%0d rdata", responses), rdata[2], exp_q.pop_front());
         end
         if (req && addr_ok[2]) begin
            exp_q.push_back(wr ? 32'h0 : vals[issued / 2]);
            accepts++;
            issued++;
         end
         next_cycle();
         cyc++;
      end
      idle_inputs();
      check("wrap accepts", 32'(accepts), 32'd20);
      check("wrap responses", 32'(responses), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
